// File: rtl/control_unit.sv
// Main instruction decoder for the 8-bit CPU: opcode + zero flag to datapath controls.
// A three-state register freezes the machine during reset hold and after HLT.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opCode,
    input  logic       zero_flag,
    output logic       PC_Enable,
    output logic       RA_Enable,
    output logic       Reg_const4,
    output logic       RegWrite_Enable,
    output logic       Reg_Imm,
    output logic       MemWrite_Enable,
    output logic [1:0] PC_RA_ALU_REG,
    output logic [1:0] Alu_Move_Mem,
    output logic [1:0] Reg_4_PC,
    output logic [2:0] ALUOP
);

    typedef enum logic [1:0] {
        RST_HOLD = 2'b00,
        RUN      = 2'b01,
        HALT     = 2'b10
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_HOLD;
        end else begin
            unique case (state)
                RST_HOLD: state <= RUN;
                RUN:      if (opCode == 4'b1111) state <= HALT;
                HALT:     state <= HALT;
                default:  state <= RST_HOLD;
            endcase
        end
    end

    always_comb begin
        PC_Enable       = 1'b0;
        RA_Enable       = 1'b0;
        Reg_const4      = 1'b0;
        RegWrite_Enable = 1'b0;
        Reg_Imm         = 1'b0;
        MemWrite_Enable = 1'b0;
        PC_RA_ALU_REG   = 2'b00;
        Alu_Move_Mem    = 2'b00;
        Reg_4_PC        = 2'b00;
        ALUOP           = 3'b000;
        if (state == RUN && opCode != 4'b1111) begin
            PC_Enable = 1'b1;
            unique case (opCode)
                4'b0000: ;
                4'b0001: RegWrite_Enable = 1'b1;
                4'b0010: begin
                    RegWrite_Enable = 1'b1;
                    ALUOP           = 3'b001;
                end
                4'b0011: begin
                    RegWrite_Enable = 1'b1;
                    ALUOP           = 3'b010;
                end
                4'b0100: begin
                    RegWrite_Enable = 1'b1;
                    ALUOP           = 3'b011;
                end
                4'b0101: begin
                    RegWrite_Enable = 1'b1;
                    ALUOP           = 3'b100;
                end
                4'b0110: begin
                    RegWrite_Enable = 1'b1;
                    Reg_const4      = 1'b1;
                    ALUOP           = 3'b101;
                end
                4'b0111: PC_RA_ALU_REG = 2'b01;
                4'b1000: begin
                    RegWrite_Enable = 1'b1;
                    Reg_Imm         = 1'b1;
                end
                4'b1001: begin
                    RegWrite_Enable = 1'b1;
                    Reg_Imm         = 1'b1;
                    Alu_Move_Mem    = 2'b01;
                end
                4'b1010: begin
                    RegWrite_Enable = 1'b1;
                    Reg_Imm         = 1'b1;
                    Alu_Move_Mem    = 2'b10;
                end
                4'b1011: begin
                    MemWrite_Enable = 1'b1;
                    Reg_Imm         = 1'b1;
                end
                // JMP / BEQZ / CALL: PC-relative target computed by the ALU
                4'b1100, 4'b1101, 4'b1110: begin
                    Reg_4_PC  = 2'b01;
                    Reg_Imm   = 1'b1;
                    RA_Enable = (opCode == 4'b1110);
                    if (opCode != 4'b1101 || zero_flag)
                        PC_RA_ALU_REG = 2'b10;
                end
                4'b1111: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words queued at drive time,
// popped and compared mid-cycle once the combinational decode has settled.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opCode;
    logic       zero_flag;
    logic       PC_Enable, RA_Enable, Reg_const4, RegWrite_Enable;
    logic       Reg_Imm, MemWrite_Enable;
    logic [1:0] PC_RA_ALU_REG, Alu_Move_Mem, Reg_4_PC;
    logic [2:0] ALUOP;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {M_HOLD, M_RUN, M_HALT} mstate_t;
    mstate_t m_state;

    logic [14:0] sb_q[$];

    control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .opCode          (opCode),
        .zero_flag       (zero_flag),
        .PC_Enable       (PC_Enable),
        .RA_Enable       (RA_Enable),
        .Reg_const4      (Reg_const4),
        .RegWrite_Enable (RegWrite_Enable),
        .Reg_Imm         (Reg_Imm),
        .MemWrite_Enable (MemWrite_Enable),
        .PC_RA_ALU_REG   (PC_RA_ALU_REG),
        .Alu_Move_Mem    (Alu_Move_Mem),
        .Reg_4_PC        (Reg_4_PC),
        .ALUOP           (ALUOP)
    );

    always #5 clk = ~clk;

    // {PC_En, RA_En, c4, RegW, Imm, MemW, pcsel[2], wb[2], asel[2], aluop[3]}
    function automatic logic [14:0] pack(
        logic pc, logic ra, logic c4, logic rw, logic im, logic mw,
        logic [1:0] ps, logic [1:0] wb, logic [1:0] as, logic [2:0] op);
        return {pc, ra, c4, rw, im, mw, ps, wb, as, op};
    endfunction

    function automatic logic [14:0] model(mstate_t st, logic [3:0] op, logic z);
        if (st != M_RUN) return '0;
        case (op)
            4'h0: return pack(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000);
            4'h1: return pack(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b000);
            4'h2: return pack(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b001);
            4'h3: return pack(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b010);
            4'h4: return pack(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b011);
            4'h5: return pack(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b100);
            4'h6: return pack(1,0,1,1,0,0,2'b00,2'b00,2'b00,3'b101);
            4'h7: return pack(1,0,0,0,0,0,2'b01,2'b00,2'b00,3'b000);
            4'h8: return pack(1,0,0,1,1,0,2'b00,2'b00,2'b00,3'b000);
            4'h9: return pack(1,0,0,1,1,0,2'b00,2'b01,2'b00,3'b000);
            4'hA: return pack(1,0,0,1,1,0,2'b00,2'b10,2'b00,3'b000);
            4'hB: return pack(1,0,0,0,1,1,2'b00,2'b00,2'b00,3'b000);
            4'hC: return pack(1,0,0,0,1,0,2'b10,2'b00,2'b01,3'b000);
            4'hD: return pack(1,0,0,0,1,0,z ? 2'b10 : 2'b00,2'b00,2'b01,3'b000);
            4'hE: return pack(1,1,0,0,1,0,2'b10,2'b00,2'b01,3'b000);
            default: return '0;
        endcase
    endfunction

    function automatic logic [14:0] observed();
        return pack(PC_Enable, RA_Enable, Reg_const4, RegWrite_Enable,
                    Reg_Imm, MemWrite_Enable, PC_RA_ALU_REG, Alu_Move_Mem,
                    Reg_4_PC, ALUOP);
    endfunction

    task automatic chk(string tag, logic [14:0] got, logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One full cycle: drive at negedge, compare before the next posedge,
    // then advance the reference state across that posedge.
    task automatic step(string tag, logic rst, logic [3:0] op, logic z);
        logic [14:0] exp;
        logic [14:0] got;
        @(negedge clk);
        reset     = rst;
        opCode    = op;
        zero_flag = z;
        sb_q.push_back(model(m_state, op, z));
        #2;
        got = observed();
        exp = sb_q.pop_front();
        chk(tag, got, exp);
        if (tag == "sweep") chk("sweep_memw", {14'd0, got[9]}, {14'd0, op == 4'hB});
        if (rst)
            m_state = M_HOLD;
        else if (m_state == M_HOLD)
            m_state = M_RUN;
        else if (m_state == M_RUN && op == 4'hF)
            m_state = M_HALT;
    endtask

    initial begin
        reset     = 1'b1;
        opCode    = 4'h0;
        zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        m_state = M_HOLD;

        step("rst_held", 1'b1, 4'h1, 1'b1);
        step("hold_1st", 1'b0, 4'h0, 1'b0);
        step("run_nop",  1'b0, 4'h0, 1'b0);

        for (int i = 0; i < 15; i++)
            step("sweep", 1'b0, 4'(i), 1'b1);

        step("beqz_z1", 1'b0, 4'hD, 1'b1);
        step("beqz_z0", 1'b0, 4'hD, 1'b0);
        step("call",    1'b0, 4'hE, 1'b0);
        step("ret",     1'b0, 4'h7, 1'b1);
        step("load",    1'b0, 4'hA, 1'b0);
        step("shl4",    1'b0, 4'h6, 1'b0);
        step("jmp_z0",  1'b0, 4'hC, 1'b0);

        step("rst_mid",   1'b1, 4'h1, 1'b0);
        step("rst_after", 1'b0, 4'h1, 1'b0);
        step("rst_recov", 1'b0, 4'h1, 1'b0);

        step("hlt",     1'b0, 4'hF, 1'b0);
        step("halt_b",  1'b0, 4'hB, 1'b1);
        step("halt_e",  1'b0, 4'hE, 1'b1);
        step("halt_f",  1'b0, 4'hF, 1'b0);
        step("halt_rst",1'b1, 4'h2, 1'b0);
        step("rec_hold",1'b0, 4'h2, 1'b0);
        step("rec_sub", 1'b0, 4'h2, 1'b0);
        step("rec_st",  1'b0, 4'hB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
